// File: rtl/moore_seq_tx.sv
// moore_seq_tx: serial stimulus transmitter for the Moore sequence detector.
//
// A burst is requested with start while idle. The pattern, length and repeat
// count are latched into shadow registers, then bits [len-1:0] of the pattern
// are shifted out MSB-first on x1, one bit per clock. Repeats are separated
// by GAP idle cycles (x1=0, tx_valid=0). A one-cycle done pulse ends the burst.
// A start with an illegal length is rejected with a one-cycle err pulse.
//
// Optional feature (macro MOORE_SEQ_TX_DET_COUNT_EN): det_count counts clocks
// with z1=1 while busy, saturating, cleared on reset and on an accepted start.
// Without the macro det_count is tied to 0 and z1 is unused.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   start      burst request, sampled only in IDLE
//   pattern    bits to send, bit len-1 first
//   len        bits per repeat, legal 1..PAT_W
//   reps       number of repeats, 0 treated as 1
//   z1         detector output (used only with the counter feature)
//   x1         registered serial bit to the detector
//   tx_valid   x1 carries a pattern bit
//   busy       high from accept through the done cycle
//   done       one-cycle end-of-burst pulse
//   err        one-cycle rejected-start pulse
//   det_count  z1 pulses counted during the current or last burst
module moore_seq_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             z1,
  output logic             x1,
  output logic             tx_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] det_count
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [PAT_W-1:0]   pat_reg, pat_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [REP_W-1:0]   rep_left_reg, rep_left_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [GAP_W-1:0]   gap_cnt_reg, gap_cnt_next;
  logic               x1_reg, x1_next;
  logic               tx_valid_reg, tx_valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               err_reg, err_next;

  logic               len_ok;
  logic               accept;
  logic [IDX_W-1:0]   start_idx;
  logic [IDX_W-1:0]   reload_idx;
  logic [IDX_W-1:0]   idx_dec;

  assign len_ok     = (len != '0) && (len <= LEN_W'(PAT_W));
  assign start_idx  = IDX_W'(len - 1'b1);
  assign reload_idx = IDX_W'(len_reg - 1'b1);
  assign idx_dec    = idx_reg - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      pat_reg      <= '0;
      len_reg      <= '0;
      rep_left_reg <= '0;
      idx_reg      <= '0;
      gap_cnt_reg  <= '0;
      x1_reg       <= 1'b0;
      tx_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pat_reg      <= pat_next;
      len_reg      <= len_next;
      rep_left_reg <= rep_left_next;
      idx_reg      <= idx_next;
      gap_cnt_reg  <= gap_cnt_next;
      x1_reg       <= x1_next;
      tx_valid_reg <= tx_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      err_reg      <= err_next;
    end
  end

  // idx_reg always names the bit currently on x1; the next-state logic
  // registers the following bit so x1 stays a clean flop output.
  always_comb begin
    state_next    = state_reg;
    pat_next      = pat_reg;
    len_next      = len_reg;
    rep_left_next = rep_left_reg;
    idx_next      = idx_reg;
    gap_cnt_next  = gap_cnt_reg;
    x1_next       = 1'b0;
    tx_valid_next = 1'b0;
    busy_next     = 1'b0;
    done_next     = 1'b0;
    err_next      = 1'b0;
    accept        = 1'b0;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            accept        = 1'b1;
            pat_next      = pattern;
            len_next      = len;
            rep_left_next = (reps == '0) ? REP_W'(1) : reps;
            idx_next      = start_idx;
            x1_next       = pattern[start_idx];
            tx_valid_next = 1'b1;
            busy_next     = 1'b1;
            state_next    = S_SEND;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      S_SEND: begin
        busy_next = 1'b1;
        if (idx_reg == '0) begin
          if (rep_left_reg > REP_W'(1)) begin
            rep_left_next = rep_left_reg - 1'b1;
            if (GAP > 0) begin
              gap_cnt_next = GAP_W'((GAP > 0) ? GAP - 1 : 0);
              state_next   = S_GAP;
            end else begin
              // No gap: the next repeat starts with no bubble.
              idx_next      = reload_idx;
              x1_next       = pat_reg[reload_idx];
              tx_valid_next = 1'b1;
            end
          end else begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end
        end else begin
          idx_next      = idx_dec;
          x1_next       = pat_reg[idx_dec];
          tx_valid_next = 1'b1;
        end
      end

      S_GAP: begin
        busy_next = 1'b1;
        if (gap_cnt_reg == '0) begin
          idx_next      = reload_idx;
          x1_next       = pat_reg[reload_idx];
          tx_valid_next = 1'b1;
          state_next    = S_SEND;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign x1       = x1_reg;
  assign tx_valid = tx_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;

`ifdef MOORE_SEQ_TX_DET_COUNT_EN
  logic [CNT_W-1:0] det_count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      det_count_reg <= '0;
    end else if (accept) begin
      det_count_reg <= '0;
    end else if (z1 && busy_reg && (det_count_reg != '1)) begin
      det_count_reg <= det_count_reg + 1'b1;
    end
  end

  assign det_count = det_count_reg;
`else
  logic unused_z1;
  assign unused_z1 = z1;
  assign det_count = '0;
`endif

endmodule

// File: tb/tb_moore_seq_tx.sv
// Testbench for moore_seq_tx (default parameters: PAT_W=8, GAP=2, CNT_W=8).
// Table of per-cycle vectors: inputs for one cycle and the outputs expected
// just after the following rising edge. A hand-written sequence covers reset
// asserted in the middle of a burst.
module tb_moore_seq_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       z1 = 1'b0;
  logic       x1, tx_valid, busy, done, err;
  logic [7:0] det_count;

  int n_vec = 0;
  int n_bad = 0;

  moore_seq_tx dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .reps      (reps),
    .z1        (z1),
    .x1        (x1),
    .tx_valid  (tx_valid),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .det_count (det_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [7:0] pattern;
    logic [3:0] len;
    logic [3:0] reps;
    logic       z1;
    logic       x1;
    logic       tv;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] det;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] edet(input logic [7:0] d);
`ifdef MOORE_SEQ_TX_DET_COUNT_EN
    return d;
`else
    return 8'd0 & d;
`endif
  endfunction

  task automatic add(input logic st, input logic [7:0] p, input logic [3:0] l,
                     input logic [3:0] rp, input logic z, input logic ex1,
                     input logic etv, input logic eb, input logic ed,
                     input logic ee, input logic [7:0] edt);
    vec_t v;
    v.start = st; v.pattern = p; v.len = l; v.reps = rp; v.z1 = z;
    v.x1 = ex1; v.tv = etv; v.busy = eb; v.done = ed; v.err = ee; v.det = edt;
    vecs.push_back(v);
  endtask

  // Non-start cycle; shadowed inputs are scrambled to show they are ignored.
  task automatic nx(input logic z, input logic ex1, input logic etv,
                    input logic eb, input logic ed, input logic ee,
                    input logic [7:0] edt);
    add(1'b0, 8'h55, 4'd0, 4'd0, z, ex1, etv, eb, ed, ee, edt);
  endtask

  task automatic drive(input logic r, input logic st, input logic [7:0] p,
                       input logic [3:0] l, input logic [3:0] rp, input logic z);
    @(negedge clk);
    rst = r; start = st; pattern = p; len = l; reps = rp; z1 = z;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int k,
                       input logic [12:0] got, input logic [12:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: x1/tv/busy/done/err/det got %b required %b",
               name, k, got, exp);
    end else begin
      $display("ok   %s[%0d]: x1/tv/busy/done/err/det %b", name, k, got);
    end
  endtask

  initial begin
    // Single burst, pattern 1011, z1 high 3 cycles in burst and once in idle.
    add(1, 8'h0B, 4, 1, 0,  1,1,1,0,0, 0);
    nx(1,  0,1,1,0,0, 1);
    nx(1,  1,1,1,0,0, 2);
    nx(1,  1,1,1,0,0, 3);
    nx(0,  0,0,1,1,0, 3);
    nx(0,  0,0,0,0,0, 3);
    nx(1,  0,0,0,0,0, 3);
    nx(0,  0,0,0,0,0, 3);
    // Two repeats with a 2-cycle gap; accepted start clears det_count.
    add(1, 8'h0B, 4, 2, 0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(1,  1,1,1,0,0, 1);
    nx(0,  1,1,1,0,0, 1);
    nx(0,  0,0,1,0,0, 1);
    nx(0,  0,0,1,0,0, 1);
    nx(0,  1,1,1,0,0, 1);
    nx(0,  0,1,1,0,0, 1);
    nx(0,  1,1,1,0,0, 1);
    nx(0,  1,1,1,0,0, 1);
    nx(0,  0,0,1,1,0, 1);
    nx(0,  0,0,0,0,0, 1);
    // Illegal lengths 0 and 9.
    add(1, 8'h0B, 0, 1, 0,  0,0,0,0,1, 1);
    nx(0,  0,0,0,0,0, 1);
    add(1, 8'h0B, 9, 1, 0,  0,0,0,0,1, 1);
    nx(0,  0,0,0,0,0, 1);
    // reps=0, start again mid-burst with a different pattern.
    add(1, 8'h0B, 4, 0, 0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    add(1, 8'hF0, 3, 5, 0,  1,1,1,0,0, 0);
    nx(0,  0,0,1,1,0, 0);
    nx(0,  0,0,0,0,0, 0);
    nx(0,  0,0,0,0,0, 0);
    // Full-width length 8, pattern 1001_0110.
    add(1, 8'h96, 8, 1, 0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  0,0,1,1,0, 0);
    nx(0,  0,0,0,0,0, 0);
    // Length 1, three repeats: bit, gap, gap, bit, gap, gap, bit, done.
    add(1, 8'h01, 1, 3, 0,  1,1,1,0,0, 0);
    nx(0,  0,0,1,0,0, 0);
    nx(0,  0,0,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  0,0,1,0,0, 0);
    nx(0,  0,0,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  0,0,1,1,0, 0);
    nx(0,  0,0,0,0,0, 0);
    // Bits above len-1 ignored (F6, len 3 -> 110); start in DONE ignored.
    add(1, 8'hF6, 3, 1, 0,  1,1,1,0,0, 0);
    nx(0,  1,1,1,0,0, 0);
    nx(0,  0,1,1,0,0, 0);
    nx(0,  0,0,1,1,0, 0);
    add(1, 8'h0B, 4, 1, 0,  0,0,0,0,0, 0);
    nx(0,  0,0,0,0,0, 0);

    // Initial reset held two cycles.
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 8'h00, 0, 0, 0);
      check("reset", i, {x1, tx_valid, busy, done, err, det_count}, 13'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].start, vecs[i].pattern, vecs[i].len, vecs[i].reps, vecs[i].z1);
      check("vec", i, {x1, tx_valid, busy, done, err, det_count},
            {vecs[i].x1, vecs[i].tv, vecs[i].busy, vecs[i].done, vecs[i].err,
             edet(vecs[i].det)});
    end

    // Reset in the middle of a burst, with z1 raising det_count beforehand.
    drive(0, 1, 8'h0B, 4, 1, 1);
    drive(0, 0, 8'h0B, 4, 1, 1);
    drive(0, 0, 8'h0B, 4, 1, 1);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 8'h0B, 4, 1, 1);
      check("rst_mid", i, {x1, tx_valid, busy, done, err, det_count}, 13'd0);
    end
    drive(0, 1, 8'h0B, 4, 1, 0);
    check("post_rst", 0, {x1, tx_valid, busy, done, err, det_count},
          {5'b11100, edet(8'd0)});
    drive(0, 0, 8'h00, 0, 0, 1);
    check("post_rst", 1, {x1, tx_valid, busy, done, err, det_count},
          {5'b01100, edet(8'd1)});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
